// File: rtl/bsu_pkg.sv
// Shared types and constants for the beam-update controller.
package bsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StShift,
    StLatch,
    StDone
  } bsu_state_e;

  localparam logic [4:0] FreqCode0 = 5'd6;
  localparam logic [4:0] FreqCode1 = 5'd10;
  localparam logic [4:0] FreqCode2 = 5'd14;
  localparam logic [4:0] FreqCode3 = 5'd18;

  localparam int unsigned PhWDef   = 5;
  localparam int unsigned NElemDef = 5;

  function automatic logic freq_legal(input logic [4:0] f);
    return (f == FreqCode0) || (f == FreqCode1) || (f == FreqCode2) || (f == FreqCode3);
  endfunction

endpackage

// File: rtl/bsu_ser_tx.sv
// Serial transmitter to the phase-shifter chain: sclk divider plus MSB-first
// parallel-load shift register.
module bsu_ser_tx #(
  parameter int unsigned WIDTH   = 25,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  output logic             busy,
  output logic             sclk,
  output logic             sdata
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             run_q, run_d;
  logic             high_q, high_d;
  logic             phase_end;
  logic             last;

  always_comb begin
    phase_end = run_q && (div_cnt_q == DivLast);
    // Final cycle of the high phase of the last bit; counters never wrap past it.
    last      = phase_end && high_q && (bit_cnt_q == BitLast);

    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    run_d     = run_q;
    high_d    = high_q;

    if (start) begin
      run_d     = 1'b1;
      high_d    = 1'b0;
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (run_q) begin
      if (!phase_end) begin
        div_cnt_d = div_cnt_q + 1'b1;
      end else begin
        div_cnt_d = '0;
        if (!high_q) begin
          high_d = 1'b1;
        end else if (last) begin
          run_d  = 1'b0;
          high_d = 1'b0;
        end else begin
          // Next bit appears at the start of the low phase.
          high_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        end
      end
    end

    if (load) begin
      shreg_d = load_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      run_q     <= 1'b0;
      high_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      run_q     <= run_d;
      high_q    <= high_d;
    end
  end

  assign busy  = run_q && !last;
  assign sclk  = high_q;
  assign sdata = shreg_q[WIDTH-1];

endmodule

// File: rtl/bsu_beam_ctrl.sv
// Beam-update controller: accepts a beam command, sequences the phase LUT bank,
// shifts the element phase words out and pulses the latch enable.
module bsu_beam_ctrl
  import bsu_pkg::*;
#(
  parameter int unsigned N_ELEM  = NElemDef,
  parameter int unsigned PH_W    = PhWDef,
  parameter int unsigned LUT_LAT = 1,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LE_CYC  = 2
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [4:0]      cmd_fvalue,
  input  logic [3:0]      cmd_tvalue,
  input  logic [1:0]      cmd_pivalue,
  output logic            flagf,
  output logic [4:0]      fvalue,
  output logic [3:0]      tvalue,
  output logic [1:0]      pivalue,
  input  logic [PH_W-1:0] eout1,
  input  logic [PH_W-1:0] eout2,
  input  logic [PH_W-1:0] eout3,
  input  logic [PH_W-1:0] eout4,
  input  logic [PH_W-1:0] eout5,
  output logic            ps_sclk,
  output logic            ps_sdata,
  output logic            ps_le,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned TotBits = N_ELEM * PH_W;
  localparam int unsigned LW = (LUT_LAT > 0) ? $clog2(LUT_LAT + 1) : 1;
  localparam int unsigned EW = (LE_CYC > 1) ? $clog2(LE_CYC) : 1;
  localparam logic [LW-1:0] LutLast = LW'(LUT_LAT);
  localparam logic [EW-1:0] LeLast  = EW'(LE_CYC - 1);

  bsu_state_e       state_q, state_d;
  logic [LW-1:0]    lut_cnt_q, lut_cnt_d;
  logic [EW-1:0]    le_cnt_q, le_cnt_d;
  logic [4:0]       fvalue_q, fvalue_d;
  logic [3:0]       tvalue_q, tvalue_d;
  logic [1:0]       pivalue_q, pivalue_d;
  logic             err_q, err_d;

  logic               tx_load;
  logic               tx_start;
  logic               tx_busy;
  logic [TotBits-1:0] tx_data;

  assign tx_data = {eout1, eout2, eout3, eout4, eout5};

  always_comb begin
    state_d   = state_q;
    lut_cnt_d = lut_cnt_q;
    le_cnt_d  = le_cnt_q;
    fvalue_d  = fvalue_q;
    tvalue_d  = tvalue_q;
    pivalue_d = pivalue_q;
    err_d     = 1'b0;
    tx_load   = 1'b0;
    tx_start  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (freq_legal(cmd_fvalue)) begin
            fvalue_d  = cmd_fvalue;
            tvalue_d  = cmd_tvalue;
            pivalue_d = cmd_pivalue;
            lut_cnt_d = '0;
            state_d   = StLookup;
          end else begin
            // Rejected command leaves the LUT inputs untouched.
            err_d = 1'b1;
          end
        end
      end
      StLookup: begin
        if (lut_cnt_q == LutLast) begin
          tx_load  = 1'b1;
          tx_start = 1'b1;
          state_d  = StShift;
        end else begin
          lut_cnt_d = lut_cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (!tx_busy) begin
          le_cnt_d = '0;
          state_d  = StLatch;
        end
      end
      StLatch: begin
        if (le_cnt_q == LeLast) begin
          state_d = StDone;
        end else begin
          le_cnt_d = le_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      lut_cnt_q <= '0;
      le_cnt_q  <= '0;
      fvalue_q  <= '0;
      tvalue_q  <= '0;
      pivalue_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lut_cnt_q <= lut_cnt_d;
      le_cnt_q  <= le_cnt_d;
      fvalue_q  <= fvalue_d;
      tvalue_q  <= tvalue_d;
      pivalue_q <= pivalue_d;
      err_q     <= err_d;
    end
  end

  bsu_ser_tx #(
    .WIDTH  (TotBits),
    .CLK_DIV(CLK_DIV)
  ) u_ser_tx (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .load     (tx_load),
    .load_data(tx_data),
    .start    (tx_start),
    .busy     (tx_busy),
    .sclk     (ps_sclk),
    .sdata    (ps_sdata)
  );

  assign cmd_ready = (state_q == StIdle);
  assign flagf     = (state_q == StLookup);
  assign busy      = (state_q == StLookup) || (state_q == StShift) || (state_q == StLatch);
  assign ps_le     = (state_q == StLatch);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign fvalue    = fvalue_q;
  assign tvalue    = tvalue_q;
  assign pivalue   = pivalue_q;

endmodule

// File: tb/tb_bsu_beam_ctrl.sv
// Directed bench for bsu_beam_ctrl: a default instance and a CLK_DIV=1,
// LUT_LAT=2, LE_CYC=1 instance driven from one command source.
module tb_bsu_beam_ctrl;

  localparam int A_LL = 1, A_CD = 4, A_LE = 2;
  localparam int B_LL = 2, B_CD = 1, B_LE = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       sel;
  logic [4:0] cmd_f;
  logic [3:0] cmd_t;
  logic [1:0] cmd_pi;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic       a_ready, a_flagf, a_sclk, a_sdata, a_le, a_busy, a_done, a_err;
  logic [4:0] a_fvalue;
  logic [3:0] a_tvalue;
  logic [1:0] a_pivalue;
  logic [4:0] a_eout [5];
  int         a_fcnt;

  logic       b_ready, b_flagf, b_sclk, b_sdata, b_le, b_busy, b_done, b_err;
  logic [4:0] b_fvalue;
  logic [3:0] b_tvalue;
  logic [1:0] b_pivalue;
  logic [4:0] b_eout [5];
  int         b_fcnt;

  // LUT model: the test-plan words for (10,3,1), otherwise a mix of the fields.
  function automatic logic [4:0] lut_model(input int k, input logic [4:0] f, input logic [3:0] t,
                                           input logic [1:0] pi);
    logic [4:0] one;
    one = 5'd1;
    if (f == 5'd10 && t == 4'd3 && pi == 2'd1) return one << k;
    return 5'(int'(f) * 3 + int'(t) * (k + 1) + int'(pi) * 7 + k);
  endfunction

  // Words are only valid once flagf has been high for LUT_LAT cycles.
  always @(posedge clk) begin
    a_fcnt <= (rst || !a_flagf) ? 0 : a_fcnt + 1;
    b_fcnt <= (rst || !b_flagf) ? 0 : b_fcnt + 1;
  end

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      a_eout[k] = (a_fcnt >= A_LL) ? lut_model(k, a_fvalue, a_tvalue, a_pivalue)
                                   : ~lut_model(k, a_fvalue, a_tvalue, a_pivalue);
      b_eout[k] = (b_fcnt >= B_LL) ? lut_model(k, b_fvalue, b_tvalue, b_pivalue)
                                   : ~lut_model(k, b_fvalue, b_tvalue, b_pivalue);
    end
  end

  bsu_beam_ctrl u_dut_a (
    .sys_clk(clk), .rst(rst), .cmd_valid(cmd_valid && !sel), .cmd_ready(a_ready),
    .cmd_fvalue(cmd_f), .cmd_tvalue(cmd_t), .cmd_pivalue(cmd_pi),
    .flagf(a_flagf), .fvalue(a_fvalue), .tvalue(a_tvalue), .pivalue(a_pivalue),
    .eout1(a_eout[0]), .eout2(a_eout[1]), .eout3(a_eout[2]), .eout4(a_eout[3]),
    .eout5(a_eout[4]), .ps_sclk(a_sclk), .ps_sdata(a_sdata), .ps_le(a_le),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  bsu_beam_ctrl #(
    .LUT_LAT(B_LL), .CLK_DIV(B_CD), .LE_CYC(B_LE)
  ) u_dut_b (
    .sys_clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel), .cmd_ready(b_ready),
    .cmd_fvalue(cmd_f), .cmd_tvalue(cmd_t), .cmd_pivalue(cmd_pi),
    .flagf(b_flagf), .fvalue(b_fvalue), .tvalue(b_tvalue), .pivalue(b_pivalue),
    .eout1(b_eout[0]), .eout2(b_eout[1]), .eout3(b_eout[2]), .eout4(b_eout[3]),
    .eout5(b_eout[4]), .ps_sclk(b_sclk), .ps_sdata(b_sdata), .ps_le(b_le),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  logic       o_ready, o_flagf, o_sclk, o_sdata, o_le, o_busy, o_done, o_err;
  logic [4:0] o_fvalue;
  logic [3:0] o_tvalue;
  logic [1:0] o_pivalue;

  assign o_ready   = sel ? b_ready   : a_ready;
  assign o_flagf   = sel ? b_flagf   : a_flagf;
  assign o_sclk    = sel ? b_sclk    : a_sclk;
  assign o_sdata   = sel ? b_sdata   : a_sdata;
  assign o_le      = sel ? b_le      : a_le;
  assign o_busy    = sel ? b_busy    : a_busy;
  assign o_done    = sel ? b_done    : a_done;
  assign o_err     = sel ? b_err     : a_err;
  assign o_fvalue  = sel ? b_fvalue  : a_fvalue;
  assign o_tvalue  = sel ? b_tvalue  : a_tvalue;
  assign o_pivalue = sel ? b_pivalue : a_pivalue;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_f = '0; cmd_t = '0; cmd_pi = '0;
    repeat (3) step();
    n_vec++;
    if ({a_ready, a_flagf, a_sclk, a_le, a_done, a_busy, a_err} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset.a_ctrl got %b want 1000000",
               {a_ready, a_flagf, a_sclk, a_le, a_done, a_busy, a_err});
    end
    rst = 1'b0;
    step();
    n_vec++;
    if ({a_ready, a_flagf, a_sclk, a_le, a_done, a_sdata, a_fvalue} !== {6'b100000, 5'd0}) begin
      n_err++;
      $display("FAIL reset.a_idle got %b want 10000000000",
               {a_ready, a_flagf, a_sclk, a_le, a_done, a_sdata, a_fvalue});
    end
    n_vec++;
    if ({b_ready, b_flagf, b_sclk, b_le, b_done, b_busy} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset.b_idle got %b want 100000",
               {b_ready, b_flagf, b_sclk, b_le, b_done, b_busy});
    end
  endtask

  // Entered in the accept cycle (cycle 0); returns in the first cycle cmd_ready is high again.
  task automatic exec_cmd(input string tag, input logic [4:0] f, input logic [3:0] t,
                          input logic [1:0] pi, input int pend_at, input logic [4:0] pf,
                          input logic [3:0] pt, input logic [1:0] ppi);
    int ll, cd, lc, shift_len, done_cyc;
    int flag_n, flag_first, le_n, le_first, done_n, done_at, ready_at;
    int busy_bad, stable_bad, err_n, rise_n, first_rise, last_hi, hi_n;
    logic [24:0] exp_bits, got_bits;
    logic prev_sclk;
    ll = sel ? B_LL : A_LL;
    cd = sel ? B_CD : A_CD;
    lc = sel ? B_LE : A_LE;
    shift_len = 2 * cd * 25;
    done_cyc = ll + 2 + shift_len + lc;
    exp_bits = {lut_model(0, f, t, pi), lut_model(1, f, t, pi), lut_model(2, f, t, pi),
                lut_model(3, f, t, pi), lut_model(4, f, t, pi)};
    got_bits = '0;
    flag_n = 0; flag_first = -1; le_n = 0; le_first = -1; done_n = 0; done_at = -1;
    ready_at = -1; busy_bad = 0; stable_bad = 0; err_n = 0; rise_n = 0; first_rise = -1;
    last_hi = -1; hi_n = 0; prev_sclk = 1'b0;

    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s.ready_at_accept got %b want 1", tag, o_ready);
    end
    cmd_f = f; cmd_t = t; cmd_pi = pi; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 400 && ready_at < 0; c++) begin
      if (o_flagf === 1'b1) begin
        flag_n++;
        if (flag_first < 0) flag_first = c;
      end
      if (o_sclk === 1'b1) begin
        hi_n++;
        last_hi = c;
        if (!prev_sclk) begin
          if (rise_n < 25) got_bits[24-rise_n] = o_sdata;
          if (first_rise < 0) first_rise = c;
          rise_n++;
        end
      end
      prev_sclk = o_sclk;
      if (o_le === 1'b1) begin
        le_n++;
        if (le_first < 0) le_first = c;
      end
      if (o_done === 1'b1) begin
        done_n++;
        done_at = c;
      end
      if (o_busy !== (c < done_cyc)) busy_bad++;
      if (c <= done_cyc && (o_fvalue !== f || o_tvalue !== t || o_pivalue !== pi)) stable_bad++;
      if (o_err !== 1'b0) err_n++;
      if (o_ready === 1'b1) begin
        ready_at = c;
      end else begin
        if (c == pend_at) begin
          cmd_f = pf; cmd_t = pt; cmd_pi = ppi; cmd_valid = 1'b1;
        end
        step();
      end
    end

    n_vec++;
    if (ready_at != done_cyc + 1) begin
      n_err++;
      $display("FAIL %s.ready_return got %0d want %0d", tag, ready_at, done_cyc + 1);
    end
    n_vec++;
    if (flag_n != ll + 1 || flag_first != 1) begin
      n_err++;
      $display("FAIL %s.flagf got n=%0d first=%0d want n=%0d first=1", tag, flag_n, flag_first,
               ll + 1);
    end
    n_vec++;
    if (rise_n != 25 || got_bits !== exp_bits) begin
      n_err++;
      $display("FAIL %s.sdata got %b (%0d edges) want %b (25 edges)", tag, got_bits, rise_n,
               exp_bits);
    end
    n_vec++;
    if (first_rise != ll + 2 + cd || last_hi != ll + 1 + shift_len || hi_n != cd * 25) begin
      n_err++;
      $display("FAIL %s.shift_window got rise=%0d last_hi=%0d hi=%0d want %0d %0d %0d", tag,
               first_rise, last_hi, hi_n, ll + 2 + cd, ll + 1 + shift_len, cd * 25);
    end
    n_vec++;
    if (le_first != done_cyc - lc || le_n != lc) begin
      n_err++;
      $display("FAIL %s.ps_le got first=%0d n=%0d want first=%0d n=%0d", tag, le_first, le_n,
               done_cyc - lc, lc);
    end
    n_vec++;
    if (done_at != done_cyc || done_n != 1) begin
      n_err++;
      $display("FAIL %s.done got at=%0d n=%0d want at=%0d n=1", tag, done_at, done_n, done_cyc);
    end
    n_vec++;
    if (busy_bad != 0 || stable_bad != 0 || err_n != 0) begin
      n_err++;
      $display("FAIL %s.busy_stable_err got %0d/%0d/%0d bad cycles want 0/0/0", tag, busy_bad,
               stable_bad, err_n);
    end
  endtask

  task automatic test_legal();
    exec_cmd("legal", 5'd10, 4'd3, 2'd1, -1, 5'd0, 4'd0, 2'd0);
  endtask

  task automatic test_illegal();
    int act;
    cmd_f = 5'd7; cmd_t = 4'd9; cmd_pi = 2'd2; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n_vec++;
    if ({o_err, o_ready, o_flagf, o_busy} !== 4'b1100) begin
      n_err++;
      $display("FAIL illegal.err_pulse got %b want 1100", {o_err, o_ready, o_flagf, o_busy});
    end
    n_vec++;
    if (o_fvalue !== 5'd10 || o_tvalue !== 4'd3 || o_pivalue !== 2'd1) begin
      n_err++;
      $display("FAIL illegal.lut_inputs got %0d/%0d/%0d want 10/3/1", o_fvalue, o_tvalue,
               o_pivalue);
    end
    act = 0;
    for (int c = 2; c <= 20; c++) begin
      step();
      if (o_err !== 1'b0 || o_flagf !== 1'b0 || o_sclk !== 1'b0 || o_le !== 1'b0 ||
          o_ready !== 1'b1) act++;
    end
    n_vec++;
    if (act != 0) begin
      n_err++;
      $display("FAIL illegal.quiet got %0d active cycles want 0", act);
    end
  endtask

  task automatic test_back_to_back();
    exec_cmd("b2b_first", 5'd14, 4'd5, 2'd2, 50, 5'd18, 4'd9, 2'd3);
    n_vec++;
    if (cmd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b.pending_held got %b want 1", cmd_valid);
    end
    exec_cmd("b2b_second", 5'd18, 4'd9, 2'd3, -1, 5'd0, 4'd0, 2'd0);
  endtask

  task automatic test_reset_mid();
    int le_seen, edges;
    logic prev;
    le_seen = 0; edges = 0; prev = 1'b0;
    cmd_f = 5'd6; cmd_t = 4'd2; cmd_pi = 2'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c < 100; c++) begin
      if (o_le === 1'b1) le_seen++;
      if (o_sclk === 1'b1 && !prev) edges++;
      prev = o_sclk;
      step();
    end
    n_vec++;
    if (o_busy !== 1'b1 || le_seen != 0 || edges == 0) begin
      n_err++;
      $display("FAIL rst_mid.pre got busy=%b le=%0d edges=%0d want busy=1 le=0 edges>0", o_busy,
               le_seen, edges);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if ({o_ready, o_busy, o_flagf, o_sclk, o_sdata, o_le, o_done, o_err} !== 8'b10000000 ||
        o_fvalue !== 5'd0 || o_tvalue !== 4'd0 || o_pivalue !== 2'd0) begin
      n_err++;
      $display("FAIL rst_mid.post got %b f=%0d t=%0d pi=%0d want 10000000 f=0 t=0 pi=0",
               {o_ready, o_busy, o_flagf, o_sclk, o_sdata, o_le, o_done, o_err}, o_fvalue,
               o_tvalue, o_pivalue);
    end
  endtask

  task automatic test_param_sweep();
    exec_cmd("sweep_a", 5'd18, 4'd7, 2'd2, -1, 5'd0, 4'd0, 2'd0);
    exec_cmd("sweep_b", 5'd10, 4'd3, 2'd1, -1, 5'd0, 4'd0, 2'd0);
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_legal();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    sel = 1'b1;
    step();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
